// File: rtl/seq_isqrt.sv
// seq_isqrt: sequential integer square root, one root bit per cycle, valid/ready on both sides.
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      synchronous reset, active-low
//   i_in_valid   operand offered        o_in_ready   block idle, operand can be accepted
//   i_in_data    unsigned operand (WIDTH bits)
//   o_out_valid  result available       i_out_ready  consumer takes the result
//   o_out_root   floor(sqrt(operand))   o_out_rem    operand - root^2 (WIDTH/2+1 bits)
//   o_busy       iterating
module seq_isqrt #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH/2-1:0] o_out_root,
  output logic [WIDTH/2:0]   o_out_rem,
  output logic               o_busy
);
  localparam int H = WIDTH / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("seq_isqrt: WIDTH must be even and >= 2");
  end
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_op;
  logic [H-1:0]     r_root;
  logic [H:0]       r_rem;
  logic [CW-1:0]    r_cnt;
  logic [H+1:0]     w_rem_sh;
  logic [H+1:0]     w_trial;
  logic [H+1:0]     w_rem_nx;
  logic             w_ge;
  // Before the last iteration the partial remainder never exceeds H bits, so dropping its
  // top bit when shifting in the next digit pair loses nothing; the compare needs H+2 bits.
  assign w_rem_sh = (H+2)'({r_rem, r_op[WIDTH-1 -: 2]});
  assign w_trial  = {r_root, 2'b01};
  assign w_ge     = w_rem_sh >= w_trial;
  assign w_rem_nx = w_ge ? w_rem_sh - w_trial : w_rem_sh;
  assign o_in_ready  = r_state == S_IDLE;
  assign o_out_valid = r_state == S_DONE;
  assign o_busy      = r_state == S_BUSY;
  assign o_out_root  = r_root;
  assign o_out_rem   = r_rem;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_in_valid) begin
        r_state <= S_BUSY;
        r_op    <= i_in_data;
        r_root  <= '0;
        r_rem   <= '0;
        r_cnt   <= '0;
      end
    end else if (r_state == S_BUSY) begin
      r_op    <= r_op << 2;
      r_root  <= (r_root << 1) | H'(w_ge);
      // The final remainder is at most 2*root, which always fits H+1 bits.
      r_rem   <= (H+1)'(w_rem_nx);
      r_cnt   <= r_cnt + 1'b1;
      r_state <= (r_cnt == CW'(H-1)) ? S_DONE : S_BUSY;
    end else if (i_out_ready) begin
      r_state <= S_IDLE;
    end
  end
endmodule
